// File: rtl/decoder_3to8_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : decoder_pkg
// Brief   : Shared widths, FSM encoding and decode helper for the sequenced
//           3-to-8 decoder.
// Revision: 1.0 - initial release
// ============================================================================
package decoder_pkg;

    localparam int CODE_W   = 3;
    localparam int ONEHOT_W = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Full decode: every code maps to exactly one set bit.
    function automatic logic [ONEHOT_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage : decoder_pkg
`default_nettype wire

// File: rtl/decoder_3to8_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : decoder_3to8_seq_if
// Brief   : Code handshake, flush and one-hot step outputs of the decoder.
// Revision: 1.0 - initial release
// ============================================================================
interface decoder_3to8_seq_if #(
    parameter int DEPTH = 4
);
    import decoder_pkg::*;

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [CODE_W-1:0]         code;
    logic [ONEHOT_W-1:0]       onehot;
    logic                      out_valid;
    logic [$clog2(DEPTH):0]    count;

    modport master (
        output flush,
        output in_valid,
        output code,
        input  in_ready,
        input  onehot,
        input  out_valid,
        input  count
    );

    modport slave (
        input  flush,
        input  in_valid,
        input  code,
        output in_ready,
        output onehot,
        output out_valid,
        output count
    );

endinterface : decoder_3to8_seq_if
`default_nettype wire

// File: rtl/decoder_3to8_seq_code_fifo.sv
`default_nettype none
// ============================================================================
// Module  : code_fifo
// Brief   : Small synchronous FIFO holding pending decode codes.
// Revision: 1.0 - initial release
// ============================================================================
module code_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     clr,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : code_fifo
`default_nettype wire

// File: rtl/decoder_3to8_seq.sv
`default_nettype none
// ============================================================================
// Module  : decoder_3to8_seq
// Brief   : Queued 3-to-8 decoder; each accepted code is driven as a
//           registered one-hot strobe for HOLD cycles.
// Revision: 1.0 - initial release
// ============================================================================
module decoder_3to8_seq
    import decoder_pkg::*;
#(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    decoder_3to8_seq_if.slave  bus
);

    localparam int c_CNT_W   = $clog2(DEPTH) + 1;
    localparam int c_TIMER_W = $clog2(HOLD + 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LOAD = c_TIMER_W'(HOLD - 1);

    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [ONEHOT_W-1:0]    r_onehot;

    state_t                 w_state_nxt;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [ONEHOT_W-1:0]    w_onehot_nxt;

    logic                   w_in_ready;
    logic                   w_push;
    logic                   w_pop;
    logic [CODE_W-1:0]      w_head;
    logic [c_CNT_W-1:0]     w_count;
    logic                   w_full;
    logic                   w_empty;

    // A full FIFO refuses pushes even when the FSM pops in the same cycle.
    assign w_in_ready = rst_n && !bus.flush && !w_full;
    assign w_push     = bus.in_valid && w_in_ready;

    code_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_code_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.code),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_onehot <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_onehot <= w_onehot_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_onehot_nxt = r_onehot;
        w_pop        = 1'b0;

        if (bus.flush) begin
            w_state_nxt  = ST_IDLE;
            w_timer_nxt  = '0;
            w_onehot_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_onehot_nxt = onehot_of(w_head);
                        w_timer_nxt  = c_TIMER_LOAD;
                        w_state_nxt  = ST_HOLD;
                    end else begin
                        w_onehot_nxt = '0;
                    end
                end
                ST_HOLD: begin
                    if (r_timer != '0) begin
                        w_timer_nxt = r_timer - c_TIMER_W'(1);
                    end else if (!w_empty) begin
                        // Next pattern follows with no idle gap.
                        w_pop        = 1'b1;
                        w_onehot_nxt = onehot_of(w_head);
                        w_timer_nxt  = c_TIMER_LOAD;
                    end else begin
                        w_onehot_nxt = '0;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_timer_nxt  = '0;
                    w_onehot_nxt = '0;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.onehot    = r_onehot;
    assign bus.out_valid = (r_onehot != '0);
    assign bus.count     = w_count;

endmodule : decoder_3to8_seq
`default_nettype wire

// File: doc/decoder_3to8_seq.md
Name: decoder_3to8_seq

Overview:
Sequenced 3-to-8 decoder, the inverse of the team's 8-to-3 one-hot encoder. It accepts 3-bit codes over a valid/ready handshake and queues them in a small FIFO. Each code is then driven as a registered one-hot 8-bit pattern for a programmable number of cycles. It sits on the producer side of the one-hot step interface and feeds strobes back to the encoder or other step consumers.

Parameters:
HOLD, 4, cycles each one-hot pattern stays asserted; legal range 1..255.
DEPTH, 4, code FIFO entries; must be a power of two, at least 2.

Ports:
clk  input  1  single clock; all state changes on the rising edge.
rst_n  input  1  synchronous reset, active-low.
flush  input  1  synchronous clear of the queue and the output.
in_valid  input  1  code present on `code`.
in_ready  output  1  block can accept a code this cycle.
code  input  3  binary index to decode.
onehot  output  8  registered one-hot pattern, 1<<code; 8'h00 when idle.
out_valid  output  1  high exactly when onehot != 0.
count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: if rst_n is low at an edge, the block clears pointers, sets count=0, onehot=8'h00 and out_valid=0, and enters IDLE.
  - in_ready is 0 while rst_n is low.
  - Reset has priority over flush and over any handshake.
- Handshake: a transfer occurs at an edge where in_valid && in_ready.
  - in_ready = rst_n && !flush && (count != DEPTH).
  - There is no same-cycle pass-through: when full, a push is refused even if a pop happens in the same cycle.
- FIFO: write and read pointers wrap modulo DEPTH.
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- FSM states: IDLE and HOLD.
  - IDLE, count>0: pop the head, load onehot=1<<head, timer=HOLD-1, go to HOLD.
  - IDLE, count==0: stay in IDLE; onehot=0.
  - HOLD, timer>0: decrement the timer; onehot is held.
  - HOLD, timer==0, count>0: pop the next code and load it directly, with no zero cycle between patterns; timer=HOLD-1.
  - HOLD, timer==0, count==0: onehot=0, go to IDLE.
- Latency: a code accepted at edge N into an empty, idle block is visible on onehot after edge N+1. It stays visible for exactly HOLD cycles.
- Throughput: one code per HOLD cycles when back-to-back.
- A push into an empty FIFO at the same edge the FSM checks count is not seen until the next edge.
- Flush (rst_n high): at the edge it clears the FIFO, sets onehot=0, and enters IDLE. A code offered in that cycle is dropped, since in_ready=0.
- Widths: the timer is clog2(HOLD+1) bits. The decode is a full 3-to-8 decode, so every code value is legal and onehot never has more than one bit set.

Decomposition:
- Shared package decoder_pkg:
  - CODE_W=3, ONEHOT_W=8.
  - state encoding IDLE/HOLD.
  - function onehot_of(code).
- One sub-module, code_fifo:
  - synchronous, DEPTH entries, CODE_W wide.
  - ports: push, pop, din, dout, count, full, empty, clr.
  - The FSM and handshake live in the top level.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1, code=3'd2.
  -> onehot=8'h00, out_valid=0, count=0, in_ready=0 throughout; nothing is queued after release.
- Single code, HOLD=4: push code=3'd5 at edge N.
  -> onehot=8'h20 and out_valid=1 after edges N+1..N+4; 8'h00 after edge N+5.
- Burst, HOLD=4, DEPTH=4: push codes 0..7 with in_valid held high.
  -> onehot walks 01,02,04,...,80, each for 4 cycles with no zero gap (32 cycles); in_ready drops whenever count==4; all 8 codes appear in order.
- Full with simultaneous pop: fill the FIFO, then offer code 3'd6 on the cycle the FSM pops.
  -> in_ready=0 that cycle and no push occurs; count goes 4->3.
  - 3'd6 is accepted on the next cycle.
- Flush mid-hold: three codes queued, assert flush during the 2nd cycle of pattern 8'h01.
  -> onehot=8'h00, count=0, IDLE after that edge; queued codes never appear.
- HOLD=1 and reset mid-operation:
  - codes 3'd7 then 3'd0 back-to-back -> 8'h80 then 8'h01 on consecutive cycles.
  - rst_n=0 during a pattern -> onehot=8'h00 and count=0 at the next edge.
